// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields and memory handshake into the control FSM,
// datapath controls and debug status out of it.
interface multicycle_ctrl_if #(
   parameter int ALUCTRL_WIDTH = 4,
   parameter int IMMSRC_WIDTH  = 3,
   parameter int RETIRE_WIDTH  = 32
);
   logic [6:0]               op;
   logic [2:0]               funct3;
   logic                     funct7_5;
   logic                     ZERO;
   logic                     mem_ready;
   logic                     MemRead;
   logic                     MemWrite;
   logic                     AdrSrc;
   logic                     IRWrite;
   logic                     PCWrite;
   logic                     RegWrite;
   logic [1:0]               ALUSrcA;
   logic [1:0]               ALUSrcB;
   logic [1:0]               ResultSrc;
   logic [ALUCTRL_WIDTH-1:0] ALUctrl;
   logic [IMMSRC_WIDTH-1:0]  Immsrc;
   logic                     illegal;
   logic [3:0]               state_out;
   logic [RETIRE_WIDTH-1:0]  retired;

   modport master (
      input  op, funct3, funct7_5, ZERO, mem_ready,
      output MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, Immsrc, illegal, state_out, retired
   );

   modport slave (
      output op, funct3, funct7_5, ZERO, mem_ready,
      input  MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ALUctrl, Immsrc, illegal, state_out, retired
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer for the multi-cycle
// RV32I core over one shared memory port; also counts retired instructions.
module multicycle_ctrl #(
   parameter int ALUCTRL_WIDTH = 4,
   parameter int IMMSRC_WIDTH  = 3,
   parameter int RETIRE_WIDTH  = 32
) (
   input logic               clk,
   input logic               rst,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      EXECI    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10,
      LUI      = 4'd11,
      ERROR    = 4'd12
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(0);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(1);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(2);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR = ALUCTRL_WIDTH'(4);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(5);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL = ALUCTRL_WIDTH'(6);
   localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL = ALUCTRL_WIDTH'(7);

   localparam logic [IMMSRC_WIDTH-1:0] IMM_I = IMMSRC_WIDTH'(0);
   localparam logic [IMMSRC_WIDTH-1:0] IMM_S = IMMSRC_WIDTH'(1);
   localparam logic [IMMSRC_WIDTH-1:0] IMM_B = IMMSRC_WIDTH'(2);
   localparam logic [IMMSRC_WIDTH-1:0] IMM_U = IMMSRC_WIDTH'(3);
   localparam logic [IMMSRC_WIDTH-1:0] IMM_J = IMMSRC_WIDTH'(4);

   state_e                   state_q, state_d;
   logic                     illegal_q;
   logic [RETIRE_WIDTH-1:0]  retired_q;
   logic                     retire;
   logic                     mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]               src_a, src_b, result_src;
   logic [ALUCTRL_WIDTH-1:0] alu_ctrl, alu_f3;
   logic [IMMSRC_WIDTH-1:0]  imm_src;

   // funct3 decode shared by register and immediate ops; SUB is picked per state
   assign alu_f3 = (bus.funct3 == 3'b111) ? ALU_AND :
                   (bus.funct3 == 3'b110) ? ALU_OR  :
                   (bus.funct3 == 3'b100) ? ALU_XOR :
                   (bus.funct3 == 3'b010) ? ALU_SLT :
                   (bus.funct3 == 3'b001) ? ALU_SLL :
                   (bus.funct3 == 3'b101) ? ALU_SRL : ALU_ADD;

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      src_a      = 2'b00;
      src_b      = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_I;
      case (state_q)
         FETCH: begin
            mem_read   = 1'b1;
            src_b      = 2'b10;
            result_src = 2'b10;
            ir_write   = bus.mem_ready;
            pc_write   = bus.mem_ready;
            state_d    = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            src_a   = 2'b01;
            src_b   = 2'b01;
            imm_src = (bus.op == OP_JAL) ? IMM_J : IMM_B;
            state_d = (bus.op == OP_LOAD || bus.op == OP_STORE) ? MEMADR :
                      (bus.op == OP_R)   ? EXECR  :
                      (bus.op == OP_I)   ? EXECI  :
                      (bus.op == OP_JAL) ? JAL    :
                      (bus.op == OP_BR)  ? BRANCH :
                      (bus.op == OP_LUI) ? LUI    : ERROR;
         end
         MEMADR: begin
            src_a   = 2'b10;
            src_b   = 2'b01;
            imm_src = (bus.op == OP_STORE) ? IMM_S : IMM_I;
            state_d = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            mem_read = 1'b1;
            adr_src  = 1'b1;
            state_d  = bus.mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         MEMWRITE: begin
            mem_write = 1'b1;
            adr_src   = 1'b1;
            retire    = bus.mem_ready;
            state_d   = bus.mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            src_a    = 2'b10;
            alu_ctrl = (bus.funct3 == 3'b000 && bus.funct7_5) ? ALU_SUB : alu_f3;
            state_d  = ALUWB;
         end
         EXECI: begin
            src_a    = 2'b10;
            src_b    = 2'b01;
            alu_ctrl = alu_f3;
            state_d  = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         // ALUOut still holds the jump target from DECODE while the ALU forms the link value
         JAL: begin
            src_a    = 2'b01;
            src_b    = 2'b10;
            pc_write = 1'b1;
            state_d  = ALUWB;
         end
         BRANCH: begin
            src_a    = 2'b10;
            alu_ctrl = ALU_SUB;
            pc_write = (bus.funct3 == 3'b000) ? bus.ZERO :
                       (bus.funct3 == 3'b001) ? !bus.ZERO : 1'b0;
            retire   = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001);
            state_d  = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001) ? FETCH : ERROR;
         end
         LUI: begin
            src_a   = 2'b11;
            src_b   = 2'b01;
            imm_src = IMM_U;
            state_d = ALUWB;
         end
         default: state_d = ERROR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == ERROR);
         if (retire) retired_q <= retired_q + RETIRE_WIDTH'(1);
      end
   end

   // controls are masked while reset is held so nothing leaks from the FETCH decode
   assign bus.MemRead   = rst & mem_read;
   assign bus.MemWrite  = rst & mem_write;
   assign bus.AdrSrc    = rst & adr_src;
   assign bus.IRWrite   = rst & ir_write;
   assign bus.PCWrite   = rst & pc_write;
   assign bus.RegWrite  = rst & reg_write;
   assign bus.ALUSrcA   = rst ? src_a : 2'b00;
   assign bus.ALUSrcB   = rst ? src_b : 2'b00;
   assign bus.ResultSrc = rst ? result_src : 2'b00;
   assign bus.ALUctrl   = rst ? alu_ctrl : ALU_ADD;
   assign bus.Immsrc    = rst ? imm_src : IMM_I;
   assign bus.illegal   = illegal_q;
   assign bus.state_out = state_q;
   assign bus.retired   = retired_q;
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the RV32I core. It replaces the single-cycle decoder's combinational control with a sequenced fetch/decode/execute/memory/writeback flow over one shared memory port, with a ready handshake to that port. It drives mux selects, write enables, ALU control and immediate select for the existing datapath blocks (ALU, reg_file, Sign_Extend, instr/data memory). It also counts retired instructions.

Parameters:
ALUCTRL_WIDTH, 4, ALU control width. Encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7.
IMMSRC_WIDTH, 3, immediate select width. Encoding: I=0, S=1, B=2, U=3, J=4.
RETIRE_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low (0 = in reset)
op  in  7  Instr[6:0] from instruction register
funct3  in  3  Instr[14:12]
funct7_5  in  1  Instr[30]
ZERO  in  1  ALU zero flag
mem_ready  in  1  shared memory port has completed the current access this cycle
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
IRWrite  out  1  latch instruction register and OldPC
PCWrite  out  1  PC register enable
RegWrite  out  1  reg_file write enable
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1 (A reg), 11 = zero
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = memory data reg, 10 = ALU result
ALUctrl  out  ALUCTRL_WIDTH  ALU operation
Immsrc  out  IMMSRC_WIDTH  immediate format
illegal  out  1  sticky; set on an unsupported opcode or branch funct3
state_out  out  4  current state code, for debug
retired  out  RETIRE_WIDTH  retired-instruction count

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, LUI=11, ERROR=12.
- Reset (rst=0, asynchronous):
  - state=FETCH, retired=0, illegal=0.
  - All outputs forced to 0 while rst=0, including MemRead.
  - The first fetch request is issued in the first cycle after rst goes high.
- Reset mid-instruction aborts the instruction: no partial register or memory write, and retired is not incremented.
- Control outputs are decoded from state (Moore) except IRWrite, PCWrite and RegWrite-on-load, which are qualified as stated below.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - Outputs: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUctrl=ADD, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, Immsrc=B, ALUctrl=ADD (branch target into ALUOut).
  - Next state by op: 0000011→MEMADR, 0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1101111→JAL, 1100011→BRANCH, 0110111→LUI, anything else→ERROR.
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUctrl=ADD; Immsrc=I for loads, S for stores.
  - Next state: MEMREAD for a load, MEMWRITE for a store.
- MEMREAD:
  - Outputs: MemRead=1, AdrSrc=1.
  - Hold while mem_ready=0; go to MEMWB on mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
- MEMWRITE:
  - Outputs: MemWrite=1, AdrSrc=1, held until mem_ready=1.
  - The write commits in the mem_ready cycle; then go to FETCH.
- EXECR:
  - Outputs: ALUSrcA=10, ALUSrcB=00.
  - ALUctrl from funct3: 000 gives ADD, or SUB if funct7_5=1; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL.
  - Go to ALUWB.
- EXECI:
  - Outputs: ALUSrcA=10, ALUSrcB=01, Immsrc=I.
  - ALUctrl uses the same funct3 map as EXECR, but funct3=000 is always ADD.
  - Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUctrl=ADD (link value OldPC+4), ResultSrc=00, PCWrite=1.
  - The PC is loaded from ALUOut, which holds the target computed in DECODE with Immsrc=J. DECODE must therefore select Immsrc=J when op=1101111.
  - Go to ALUWB.
- LUI:
  - Outputs: ALUSrcA=11, ALUSrcB=01, Immsrc=U, ALUctrl=ADD.
  - Go to ALUWB.
- BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUctrl=SUB, ResultSrc=00.
  - PCWrite = ZERO when funct3=000 (beq); PCWrite = !ZERO when funct3=001 (bne).
  - Go to FETCH. Any other funct3 goes to ERROR with PCWrite=0.
- ERROR: all enables 0, illegal=1. The only exit is reset.
- retired increments by 1, wrapping modulo 2^RETIRE_WIDTH, on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
- Zero-wait-state latencies: lw 5, sw 4, R/I/lui/jal 4, branch 3 cycles.
- Each memory wait cycle adds 1 cycle.

Test Plan:
- Reset then R-type: hold rst=0 for 3 cycles and check all outputs 0. Release, mem_ready=1, op=0110011, funct3=000, funct7_5=1 → states 0,1,6,7,0; ALUctrl=SUB in EXECR; RegWrite=1 only in ALUWB; retired=1.
- Load with waits: op=0000011, mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMREAD → FETCH lasts 3 cycles; IRWrite and PCWrite pulse once each; MEMREAD lasts 4 cycles; total 10 cycles; retired=1.
- Branches: beq with ZERO=1 → PCWrite=1 in BRANCH, 3 cycles. bne with ZERO=1 → PCWrite=0. funct3=100 → ERROR, illegal=1 and sticky.
- Store: op=0100011 → MemWrite=1 with AdrSrc=1 held across waits; RegWrite stays 0 throughout; Immsrc=S in MEMADR.
- Illegal opcode op=1111111 → ERROR after DECODE; outputs stay 0 for 20 cycles. rst=0 → state 0, illegal=0 asynchronously, before the next clock edge.
- Mid-op reset: assert rst=0 during MEMWRITE → MemWrite drops immediately, retired unchanged. Also run 100 back-to-back addi instructions → retired=100.
